// File: rtl/systolic_seq_pkg.sv
// Shared types and constants for the systolic array run sequencer.
package systolic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    READOUT,
    DONE
  } seq_state_e;

  localparam int DEF_ARRAY_DIM = 4;
  localparam int NUM_RESULTS   = DEF_ARRAY_DIM * DEF_ARRAY_DIM;
  localparam int RES_SEL_W     = $clog2(NUM_RESULTS);

endpackage

// File: rtl/seq_valid_delay.sv
// Fixed-latency valid shift register: re-times the BRAM enable so it lines up
// with read data arriving at the array inputs. Synchronous clear flushes it.
module seq_valid_delay #(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [LAT-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Single-shot run sequencer for the Booth systolic array and operand BRAMs A/B.
// Define SEQ_PERF_CNT_EN to add the last_run_cycles performance output.
module systolic_seq_ctrl
  import systolic_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int K_LEN        = 8,
  parameter int BRAM_LAT     = 1,
  parameter int DRAIN_CYCLES = 7,
  parameter int ARRAY_DIM    = DEF_ARRAY_DIM
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   ena,
  output logic                                   enb,
  output logic [ADDR_WIDTH-1:0]                  addra,
  output logic [ADDR_WIDTH-1:0]                  addrb,
  output logic                                   arr_clear,
  output logic                                   arr_feed,
  output logic [$clog2(ARRAY_DIM*ARRAY_DIM)-1:0] res_sel,
  output logic                                   res_valid,
  input  logic                                   res_ready
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                            last_run_cycles
`endif
);

  localparam int NRES      = ARRAY_DIM * ARRAY_DIM;
  localparam int SEL_W     = $clog2(NRES);
  localparam int DRAIN_LEN = BRAM_LAT + DRAIN_CYCLES;
  localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(K_LEN - 1);
  localparam logic [SEL_W-1:0]      SEL_LAST  = SEL_W'(NRES - 1);
  localparam logic [DCNT_W-1:0]     DCNT_LOAD = DCNT_W'(DRAIN_LEN);

  seq_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
  logic [SEL_W-1:0]        rsel_q, rsel_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ena_q, ena_d;
  logic                    clr_q, clr_d;
  logic                    rvld_q, rvld_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dcnt_d  = dcnt_q;
    rsel_d  = rsel_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FETCH;
        addr_d  = '0;
      end
      FETCH: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
          addr_d  = '0;
          dcnt_d  = DCNT_LOAD;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Counter spans BRAM latency plus array drain so READOUT sees final sums.
        dcnt_d = dcnt_q - DCNT_W'(1);
        if (dcnt_q == DCNT_W'(1)) begin
          state_d = READOUT;
          rsel_d  = '0;
        end
      end
      READOUT: begin
        if (res_ready) begin
          if (rsel_q == SEL_LAST) begin
            state_d = DONE;
            rsel_d  = '0;
          end else begin
            rsel_d = rsel_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    ena_d  = (state_d == FETCH);
    clr_d  = (state_d == CLEAR);
    rvld_d = (state_d == READOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dcnt_q  <= '0;
      rsel_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      clr_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dcnt_q  <= dcnt_d;
      rsel_q  <= rsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
      clr_q   <= clr_d;
      rvld_q  <= rvld_d;
    end
  end

  seq_valid_delay #(
    .LAT (BRAM_LAT)
  ) u_feed_dly (
    .clk_i (clk),
    .clr_i (reset),
    .vld_i (ena_q),
    .vld_o (arr_feed)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ena       = ena_q;
  assign enb       = ena_q;
  assign addra     = addr_q;
  assign addrb     = addr_q;
  assign arr_clear = clr_q;
  assign res_sel   = rsel_q;
  assign res_valid = rvld_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] last_q, last_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The DONE cycle itself is part of the run, hence the increment on capture.
  always_comb begin
    run_cnt_d = run_cnt_q;
    last_d    = last_q;
    if (done_q) begin
      last_d    = sat_inc16(run_cnt_q);
      run_cnt_d = '0;
    end else if (busy_q) begin
      run_cnt_d = sat_inc16(run_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= '0;
      last_q    <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      last_q    <= last_d;
    end
  end

  assign last_run_cycles = last_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: run-timeline model plus directed and random stimulus.
module tb_systolic_seq_ctrl;

  localparam int AW = 3;
  localparam int K  = 8;
  localparam int L  = 1;
  localparam int D  = 7;
  localparam int NR = 16;
  localparam int R0 = K + 2 + L + D;  // cycle offset of first readout within a run

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, res_ready;
  logic          busy, done, ena, enb, arr_clear, arr_feed, res_valid;
  logic [AW-1:0] addra, addrb;
  logic [3:0]    res_sel;

  logic          start2, res_ready2;
  logic          busy2, done2, ena2, enb2, arr_clear2, arr_feed2, res_valid2;
  logic [AW-1:0] addra2, addrb2;
  logic [3:0]    res_sel2;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]   lrc, lrc2;
`endif

  systolic_seq_ctrl #(
    .ADDR_WIDTH(AW), .K_LEN(K), .BRAM_LAT(L), .DRAIN_CYCLES(D), .ARRAY_DIM(4)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ena(ena), .enb(enb), .addra(addra), .addrb(addrb),
    .arr_clear(arr_clear), .arr_feed(arr_feed), .res_sel(res_sel),
    .res_valid(res_valid), .res_ready(res_ready)
`ifdef SEQ_PERF_CNT_EN
    , .last_run_cycles(lrc)
`endif
  );

  systolic_seq_ctrl #(
    .ADDR_WIDTH(AW), .K_LEN(1), .BRAM_LAT(2), .DRAIN_CYCLES(D), .ARRAY_DIM(4)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .ena(ena2), .enb(enb2), .addra(addra2), .addrb(addrb2),
    .arr_clear(arr_clear2), .arr_feed(arr_feed2), .res_sel(res_sel2),
    .res_valid(res_valid2), .res_ready(res_ready2)
`ifdef SEQ_PERF_CNT_EN
    , .last_run_cycles(lrc2)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline of offsets t since start was taken,
  // with the readout index advancing only on accepted handshakes.
  bit          m_run, m_fin;
  int          m_t, m_ridx;
  logic [L-1:0] ena_hist;
  bit          chk_en = 1'b0;

  function automatic logic e_ena();
    return m_run && !m_fin && m_t >= 2 && m_t <= K + 1;
  endfunction
  function automatic int e_addr();
    return e_ena() ? m_t - 2 : 0;
  endfunction
  function automatic logic e_rvld();
    return m_run && !m_fin && m_t >= R0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0; m_fin <= 1'b0; m_t <= 0; m_ridx <= 0; ena_hist <= '0;
    end else begin
      ena_hist <= L'({ena_hist, e_ena()});
      if (!m_run) begin
        if (start) begin
          m_run <= 1'b1; m_fin <= 1'b0; m_t <= 1; m_ridx <= 0;
        end
      end else if (m_fin) begin
        m_run <= 1'b0; m_fin <= 1'b0; m_t <= 0;
      end else if (m_t >= R0) begin
        if (res_ready) begin
          if (m_ridx == NR - 1) begin
            m_fin <= 1'b1; m_ridx <= 0;
          end else begin
            m_ridx <= m_ridx + 1;
          end
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      32'(busy),      32'(m_run));
      chk("done",      32'(done),      32'(m_run && m_fin));
      chk("arr_clear", 32'(arr_clear), 32'(m_run && m_t == 1));
      chk("ena",       32'(ena),       32'(e_ena()));
      chk("enb",       32'(enb),       32'(e_ena()));
      chk("addra",     32'(addra),     e_addr());
      chk("addrb",     32'(addrb),     e_addr());
      chk("arr_feed",  32'(arr_feed),  32'(ena_hist[L-1]));
      chk("res_valid", 32'(res_valid), 32'(e_rvld()));
      chk("res_sel",   32'(res_sel),   e_rvld() ? m_ridx : 0);
    end
  end

  task automatic run_measure(input string nm, input int bp_len, input bit pulses,
                             input bit timing, input int exp_len);
    int nbusy = 0;
    int ndone = 0;
    int held  = 0;
    bit fin   = 1'b0;
    start = 1'b1;
    res_ready = 1'b1;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      start = pulses && (c == 4 || c == 19);
      if (busy) nbusy++;
      if (done) ndone++;
      if (bp_len > 0 && res_valid && res_sel == 4'd3 && held < bp_len) begin
        res_ready = 1'b0;
        held++;
      end else begin
        res_ready = 1'b1;
      end
      if (timing) begin
        case (c)
          1:  begin chk("t1_clear", 32'(arr_clear), 1); chk("t1_busy", 32'(busy), 1); end
          2:  begin chk("t2_addra", 32'(addra), 0); chk("t2_ena", 32'(ena), 1); end
          3:  chk("t3_feed", 32'(arr_feed), 1);
          9:  begin chk("t9_addra", 32'(addra), 7); chk("t9_enb", 32'(enb), 1); end
          10: begin chk("t10_ena", 32'(ena), 0); chk("t10_feed", 32'(arr_feed), 1); end
          11: chk("t11_feed", 32'(arr_feed), 0);
          17: chk("t17_rvld", 32'(res_valid), 0);
          18: begin chk("t18_rvld", 32'(res_valid), 1); chk("t18_sel", 32'(res_sel), 0); end
          33: chk("t33_sel", 32'(res_sel), 15);
          34: begin chk("t34_done", 32'(done), 1); chk("t34_busy", 32'(busy), 1); end
          35: begin chk("t35_busy", 32'(busy), 0); chk("t35_done", 32'(done), 0); end
          default: ;
        endcase
      end
      if (c > 1 && !busy) fin = 1'b1;
    end
    chk({nm, "_finished"}, 32'(fin), 1);
    chk({nm, "_busy_len"}, nbusy, exp_len);
    chk({nm, "_done_cnt"}, ndone, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr1, clr2, nd, cnt;
    bit hit;
    reset = 1'b1; start = 1'b0; res_ready = 1'b1;
    start2 = 1'b0; res_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_addra", 32'(addra), 0);
    chk("rst_sel",   32'(res_sel), 0);
    chk("rst_feed",  32'(arr_feed), 0);
    chk("rst_busy2", 32'(busy2), 0);

    run_measure("basic", 0, 1'b0, 1'b1, 34);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_basic", 32'(lrc), 34);
`endif
    run_measure("backpressure", 5, 1'b0, 1'b0, 39);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_bp", 32'(lrc), 39);
`endif
    run_measure("start_ignored", 0, 1'b1, 1'b0, 34);

    // Mid-run reset at FETCH addr 4.
    start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      hit = ena && addra == 3'd4;
    end
    chk("midrst_reached", 32'(hit), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy",  32'(busy), 0);
    chk("midrst_ena",   32'(ena), 0);
    chk("midrst_addra", 32'(addra), 0);
    chk("midrst_feed",  32'(arr_feed), 0);
    chk("midrst_rvld",  32'(res_valid), 0);
    run_measure("after_rst", 0, 1'b0, 1'b1, 34);

    // Back-to-back with start held high.
    start = 1'b1;
    clr1 = 0; clr2 = 0; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (arr_clear && clr1 == 0) clr1 = c;
      else if (arr_clear && clr2 == 0) clr2 = c;
      if (done) nd++;
      if (c == 37) begin
        chk("b2b_addra", 32'(addra), 0);
        chk("b2b_ena", 32'(ena), 1);
      end
    end
    start = 1'b0;
    chk("b2b_clr1", clr1, 1);
    chk("b2b_clr2", clr2, 36);
    chk("b2b_done", nd, 1);
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      hit = !busy;
    end
    chk("b2b_idle", 32'(hit), 1);

    // Randomized start / backpressure / reset traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 149) == 0);
      start     = ($urandom_range(0, 7) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; res_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = !busy;
    end
    chk("rand_idle", 32'(hit), 1);

    // K_LEN=1, BRAM_LAT=2 instance.
    begin
      int nb = 0, ne = 0, neb = 0, fe = 0, nf = 0, ff = 0, dc = 0, nv = 0, nc = 0, ls = 0;
      start2 = 1'b1;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (busy2) nb++;
        if (ena2) begin
          ne++;
          if (fe == 0) fe = c;
          chk("d2_addr", 32'({addra2, addrb2}), 0);
        end
        if (enb2) neb++;
        if (arr_feed2) begin nf++; if (ff == 0) ff = c; end
        if (done2) dc = c;
        if (arr_clear2) nc++;
        if (res_valid2) begin nv++; ls = res_sel2; end
      end
      chk("d2_busy_len", nb, 28);
      chk("d2_ena_cnt", ne, 1);
      chk("d2_enb_cnt", neb, 1);
      chk("d2_ena_cyc", fe, 2);
      chk("d2_feed_cnt", nf, 1);
      chk("d2_feed_cyc", ff, 4);
      chk("d2_done_cyc", dc, 28);
      chk("d2_clr_cnt", nc, 1);
      chk("d2_rvld_cnt", nv, 16);
      chk("d2_last_sel", ls, 15);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_d2", 32'(lrc2), 28);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
